axi4_awch_arbiter: RTL

// - Round-robin arbiter sharing one AXI4 AW channel between N_SLAVES requesters.
// - Registered output stage feeds the downstream AW buffer.
// - Records the grant order in an order FIFO so the W-channel mux forwards write data in AW order.
// - Sits in the RAB slave-side write path, ahead of the AW buffer.

---
 rtl/axi4_awch_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_awch_arbiter.sv
// ----------------------------------------------------------------------------
// axi4_awch_arbiter
//
// Round-robin arbiter that shares one AXI4 AW channel between N_SLAVES
// requesters. The winning request is captured into a registered output
// stage that feeds the downstream AW buffer, and the winner's index is
// recorded in a small order FIFO so the W-channel mux can forward write
// data in the same order the addresses were issued.
//
// Optional feature macro: AXI4_AWARB_ID_EXT_EN
//   When defined, the grant index is appended above the user field of
//   m_aw_data (bits [AW_W+IDX_W-1:AW_W]) so the B path can route responses
//   back to the originating requester. When undefined, m_aw_data is the
//   unmodified AW payload.
//
// Ports
//   axi4_aclk      in   clock
//   axi4_arstn     in   asynchronous active-low reset
//   s_aw_data      in   packed AW payloads, slot i = [i*AW_W +: AW_W]
//   s_aw_valid     in   per-requester AWVALID
//   s_aw_ready     out  per-requester AWREADY (one-hot or zero)
//   m_aw_data      out  granted payload (plus grant index if enabled)
//   m_aw_valid     out  downstream AWVALID
//   m_aw_ready     in   downstream AWREADY
//   w_order_idx    out  requester index of the oldest un-retired AW
//   w_order_valid  out  order FIFO non-empty
//   w_order_pop    in   pulse on WLAST handshake, retires the head entry
//
// Payload layout (LSB first): cache[3:0] prot[6:4] lock[7] burst[9:8]
// size[12:10] len[20:13] addr[52:21] region[56:53] qos[60:57]
// id[60+ID:61] user[msb:61+ID]. The payload is passed through unmodified.
// ----------------------------------------------------------------------------
module axi4_awch_arbiter #(
  parameter  int N_SLAVES         = 4,
  parameter  int C_AXI_ID_WIDTH   = 4,
  parameter  int C_AXI_USER_WIDTH = 4,
  parameter  int ORDER_DEPTH      = 8,
  localparam int AW_W             = C_AXI_ID_WIDTH + C_AXI_USER_WIDTH + 61,
  localparam int IDX_W            = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
`ifdef AXI4_AWARB_ID_EXT_EN
  localparam int OUT_W            = AW_W + IDX_W
`else
  localparam int OUT_W            = AW_W
`endif
) (
  input  logic                     axi4_aclk,
  input  logic                     axi4_arstn,
  input  logic [N_SLAVES*AW_W-1:0] s_aw_data,
  input  logic [N_SLAVES-1:0]      s_aw_valid,
  output logic [N_SLAVES-1:0]      s_aw_ready,
  output logic [OUT_W-1:0]         m_aw_data,
  output logic                     m_aw_valid,
  input  logic                     m_aw_ready,
  output logic [IDX_W-1:0]         w_order_idx,
  output logic                     w_order_valid,
  input  logic                     w_order_pop
);

  localparam int CNT_W  = $clog2(ORDER_DEPTH + 1);
  localparam int PTR_W  = $clog2(ORDER_DEPTH);
  localparam int CAND_W = IDX_W + 1;

  logic [IDX_W-1:0]  rr_ptr;
  logic [CAND_W-1:0] cand;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [AW_W-1:0]   grant_payload;

  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;

  logic [IDX_W-1:0]  order_mem [ORDER_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Round-robin search: walk the requesters starting at the RR pointer and
  // wrap past the top. The candidate index is kept one bit wider than needed
  // so rr_ptr + k never overflows before the modulo subtraction.
  always_comb begin
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      cand = {1'b0, rr_ptr} + CAND_W'(k);
      if (cand >= CAND_W'(N_SLAVES)) begin
        cand = cand - CAND_W'(N_SLAVES);
      end
      if (!grant_found && s_aw_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // A new AW can be taken when the output slot is free (or draining this
  // cycle) and the order FIFO has room. Reset gates acceptance so that no
  // ready can leak out while the block is held in reset.
  assign fifo_full     = (count == CNT_W'(ORDER_DEPTH));
  assign accept        = axi4_arstn & (~m_aw_valid | m_aw_ready) & ~fifo_full;
  assign push          = accept & grant_found;
  assign pop           = w_order_pop & (count != '0);
  assign grant_payload = s_aw_data[grant_idx*AW_W +: AW_W];

  // Ready goes only to the current winner, so at most one bit is ever set.
  always_comb begin
    s_aw_ready = '0;
    if (push) begin
      s_aw_ready[grant_idx] = 1'b1;
    end
  end

  // Registered output stage. A fresh grant overwrites the slot (legal since
  // accept implies the slot is empty or handing off this cycle); otherwise
  // the payload is held until the downstream handshake clears valid.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      m_aw_valid <= 1'b0;
      m_aw_data  <= '0;
    end else if (push) begin
      m_aw_valid <= 1'b1;
`ifdef AXI4_AWARB_ID_EXT_EN
      m_aw_data  <= {grant_idx, grant_payload};
`else
      m_aw_data  <= grant_payload;
`endif
    end else if (m_aw_ready) begin
      m_aw_valid <= 1'b0;
    end
  end

  // The RR pointer moves to just past the winner so that requester gets the
  // lowest priority on the next round.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      rr_ptr <= '0;
    end else if (push) begin
      if (grant_idx == IDX_W'(N_SLAVES - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= grant_idx + 1'b1;
      end
    end
  end

  // Order FIFO storage. Entries are only ever read through rd_ptr while the
  // count says they are live, so the array itself needs no reset.
  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      order_mem[wr_ptr] <= grant_idx;
    end
  end

  // Order FIFO pointers and occupancy. Depth is a power of two, so the
  // pointers wrap naturally. A pop on an empty FIFO has already been
  // filtered out, and a push can never happen while full.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head index is forced to zero while empty so the output has a defined
  // value in and right after reset.
  assign w_order_valid = (count != '0);
  assign w_order_idx   = w_order_valid ? order_mem[rd_ptr] : '0;

endmodule
